video_timing_detect: RTL and testbench

- Receiver side of the VGA timing interface. Samples an incoming hsync/vsync/blank stream in the pixel-clock domain.
- Measures line period and frame length, and classifies the stream as 704x480 (910x525) or 640x480 (800x525).
- Recovers the active-pixel position and declares lock after consecutive clean frames.
- Used for loopback self-test of the timing generator and for capturing external video into the line buffer.

---
 rtl/video_timing_detect.sv | 253 +++++++++++++++++++++++++
 tb/tb_video_timing_detect.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_detect.sv
// video_timing_detect
//
// Receiver for a VGA-style hsync/vsync/blank stream in the pixel-clock
// domain. Measures the line period and frame length, classifies the stream
// as 910-clock lines (704x480, mode 0) or 800-clock lines (640x480, mode 1),
// recovers the active-pixel position and declares lock after LOCK_FRAMES
// consecutive clean frames.
//
// Ports:
//   clk      pixel clock; every input is synchronous to it
//   rst_n    asynchronous active-low reset
//   hsync    active-low horizontal sync
//   vsync    active-low vertical sync
//   blank    high outside the active area
//   hperiod  last measured line length in clocks
//   vlines   last measured frame length in lines
//   mode     0 = 704x480, 1 = 640x480; meaningful while locked
//   locked   high while the FSM is in LOCKED
//   err      one-cycle pulse on the LOCKED -> UNLOCKED transition
//   hpos     clocks since the start of the active line
//   vpos     active line index within the frame
//
// Handshake: there is none; every input is sampled on every clock and every
// output is a registered level (err is a single-cycle registered pulse).
module video_timing_detect #(
    parameter int LOCK_FRAMES = 2,
    parameter int FRAME_LINES = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank,
    output logic [9:0] hperiod,
    output logic [9:0] vlines,
    output logic       mode,
    output logic       locked,
    output logic       err,
    output logic [9:0] hpos,
    output logic [8:0] vpos
);
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [10:0] FRAME_LINES_W = 11'(FRAME_LINES);
    localparam logic [3:0]  LOCK_FRAMES_W = 4'(LOCK_FRAMES);
    localparam logic [10:0] LEN_640       = 11'd800;
    localparam logic [10:0] LEN_704       = 11'd910;

    state_t      state_q, state_d;
    logic        prev_hsync_q, prev_hsync_d;
    logic        prev_vsync_q, prev_vsync_d;
    logic        prev_blank_q, prev_blank_d;
    logic [9:0]  hcnt_q, hcnt_d;
    logic        hs_seen_q, hs_seen_d;
    logic [9:0]  hperiod_q, hperiod_d;
    logic [9:0]  lcnt_q, lcnt_d;
    logic [9:0]  vlines_q, vlines_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic        frame_ok_q, frame_ok_d;
    logic        class_q, class_d;
    logic        class_valid_q, class_valid_d;
    logic        mode_q, mode_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic [9:0]  hpos_q, hpos_d;
    logic [8:0]  vpos_q, vpos_d;
    logic        vpos_first_q, vpos_first_d;

    logic        hs_fall, vs_fall, bl_fall;
    logic        timeout, line_valid, line_good, line_class;
    logic [10:0] line_len, frame_len;
    logic        ok_now, cls_now, cls_valid_now;

    always_comb begin
        // Events fire in the first cycle the input is seen low.
        hs_fall    = prev_hsync_q & ~hsync;
        vs_fall    = prev_vsync_q & ~vsync;
        bl_fall    = prev_blank_q & ~blank;
        prev_hsync_d = hsync;
        prev_vsync_d = vsync;
        prev_blank_d = blank;

        // 11-bit sums so a saturated counter cannot wrap into a legal length.
        line_len   = {1'b0, hcnt_q} + 11'd1;
        frame_len  = {1'b0, lcnt_q} + {10'd0, hs_fall};
        // Pulses once, on the clock where hcnt climbs to 1023.
        timeout    = ~hs_fall & (hcnt_q == 10'd1022);
        line_valid = hs_fall & hs_seen_q;
        line_good  = (line_len == LEN_640) | (line_len == LEN_704);
        line_class = (line_len == LEN_640);

        // Line period measurement
        hcnt_d    = hcnt_q;
        hs_seen_d = hs_seen_q;
        hperiod_d = hperiod_q;
        if (hs_fall) begin
            hcnt_d    = 10'd0;
            hs_seen_d = 1'b1;
            if (hs_seen_q) hperiod_d = line_len[9:0];
        end else begin
            if (hcnt_q != 10'd1023) hcnt_d = hcnt_q + 10'd1;
            if (timeout) hs_seen_d = 1'b0;
        end

        // Frame length: an hsync edge coincident with vsync closes the old frame.
        lcnt_d   = lcnt_q;
        vlines_d = vlines_q;
        if (vs_fall) begin
            vlines_d = frame_len[9:0];
            lcnt_d   = 10'd0;
        end else if (hs_fall && lcnt_q != 10'd1023) begin
            lcnt_d = lcnt_q + 10'd1;
        end

        // Lock FSM
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        frame_ok_d    = frame_ok_q;
        class_d       = class_q;
        class_valid_d = class_valid_q;
        mode_d        = mode_q;
        ok_now        = frame_ok_q;
        cls_now       = class_q;
        cls_valid_now = class_valid_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (vs_fall) begin
                    state_d       = ST_ACQUIRE;
                    good_cnt_d    = 4'd0;
                    frame_ok_d    = 1'b1;
                    class_valid_d = 1'b0;
                end
            end
            ST_ACQUIRE: begin
                // The first good line after entering ACQUIRE fixes the class;
                // later lines must agree with it.
                if (line_valid) begin
                    if (!line_good) begin
                        ok_now = 1'b0;
                    end else if (!class_valid_q) begin
                        cls_valid_now = 1'b1;
                        cls_now       = line_class;
                    end else if (line_class != class_q) begin
                        ok_now = 1'b0;
                    end
                end
                frame_ok_d    = ok_now;
                class_d       = cls_now;
                class_valid_d = cls_valid_now;
                if (timeout) begin
                    state_d = ST_UNLOCKED;
                end else if (vs_fall) begin
                    frame_ok_d = 1'b1;
                    if (ok_now && frame_len == FRAME_LINES_W) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_d == LOCK_FRAMES_W) begin
                            state_d = ST_LOCKED;
                            mode_d  = cls_now;
                        end
                    end else begin
                        good_cnt_d = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (timeout ||
                    (line_valid && (!line_good || line_class != mode_q)) ||
                    (vs_fall && frame_len != FRAME_LINES_W)) begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
        locked_d = (state_d == ST_LOCKED);
        err_d    = (state_q == ST_LOCKED) && (state_d == ST_UNLOCKED);

        // Active position recovery
        hpos_d = hpos_q;
        if (bl_fall) begin
            hpos_d = 10'd0;
        end else if (!blank && hpos_q != 10'd1023) begin
            hpos_d = hpos_q + 10'd1;
        end

        vpos_d       = vpos_q;
        vpos_first_d = vpos_first_q;
        if (bl_fall) begin
            vpos_first_d = 1'b0;
            if (vpos_first_q) begin
                vpos_d = 9'd0;
            end else if (vpos_q != 9'd511) begin
                vpos_d = vpos_q + 9'd1;
            end
        end
        if (vs_fall) vpos_first_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_UNLOCKED;
            prev_hsync_q  <= 1'b1;
            prev_vsync_q  <= 1'b1;
            prev_blank_q  <= 1'b1;
            hcnt_q        <= 10'd0;
            hs_seen_q     <= 1'b0;
            hperiod_q     <= 10'd0;
            lcnt_q        <= 10'd0;
            vlines_q      <= 10'd0;
            good_cnt_q    <= 4'd0;
            frame_ok_q    <= 1'b0;
            class_q       <= 1'b0;
            class_valid_q <= 1'b0;
            mode_q        <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            hpos_q        <= 10'd0;
            vpos_q        <= 9'd0;
            vpos_first_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_hsync_q  <= prev_hsync_d;
            prev_vsync_q  <= prev_vsync_d;
            prev_blank_q  <= prev_blank_d;
            hcnt_q        <= hcnt_d;
            hs_seen_q     <= hs_seen_d;
            hperiod_q     <= hperiod_d;
            lcnt_q        <= lcnt_d;
            vlines_q      <= vlines_d;
            good_cnt_q    <= good_cnt_d;
            frame_ok_q    <= frame_ok_d;
            class_q       <= class_d;
            class_valid_q <= class_valid_d;
            mode_q        <= mode_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            vpos_first_q  <= vpos_first_d;
        end
    end

    assign hperiod = hperiod_q;
    assign vlines  = vlines_q;
    assign mode    = mode_q;
    assign locked  = locked_q;
    assign err     = err_q;
    assign hpos    = hpos_q;
    assign vpos    = vpos_q;
endmodule

// File: tb/tb_video_timing_detect.sv
// Directed bench for video_timing_detect.
// Horizontal timing is real (800 and 910 clock lines). The vertical timing is
// scaled down so whole frames stay short: FRAME_LINES = 4, lines 0..1 are
// active, vsync falls on line 2 (at h=0, or at the hsync edge for the
// coincident case) and stays low to the end of the frame. A "short frame" is
// therefore 3 lines instead of 524.
module tb_video_timing_detect;
    localparam int LOCK_FRAMES = 2;
    localparam int FRAME_LINES = 4;
    localparam int VS_LINE     = 2;
    localparam int ACT_LINES   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync, vsync, blank;
    logic [9:0] hperiod, vlines, hpos;
    logic [8:0] vpos;
    logic       mode, locked, err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;

    // current timing
    int t_hlen, t_hs_s, t_hs_e, t_act_w, t_vs_h;

    video_timing_detect #(
        .LOCK_FRAMES(LOCK_FRAMES),
        .FRAME_LINES(FRAME_LINES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .blank(blank),
        .hperiod(hperiod), .vlines(vlines), .mode(mode), .locked(locked),
        .err(err), .hpos(hpos), .vpos(vpos)
    );

    // clock / reset
    always #5 clk = ~clk;

    // counts clock cycles with err high
    always @(negedge clk) if (err === 1'b1) err_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic apply_reset();
        rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic step(input logic hs, input logic vs, input logic bl);
        hsync = hs; vsync = vs; blank = bl;
        @(posedge clk); #1;
    endtask

    task automatic drive_pixels(input int line, input int h_from, input int h_to);
        for (int h = h_from; h <= h_to; h++) begin
            step(!(h >= t_hs_s && h <= t_hs_e),
                 !((line == VS_LINE && h >= t_vs_h) || line > VS_LINE),
                 !(line < ACT_LINES && h < t_act_w));
        end
    endtask

    task automatic drive_line(input int line, input int hlen);
        drive_pixels(line, 0, hlen - 1);
    endtask

    task automatic drive_frame(input int nlines);
        for (int l = 0; l < nlines; l++) drive_line(l, t_hlen);
    endtask

    task automatic set_640(input int vs_h);
        t_hlen = 800; t_hs_s = 656; t_hs_e = 751; t_act_w = 640; t_vs_h = vs_h;
    endtask

    task automatic set_704(input int vs_h);
        t_hlen = 910; t_hs_s = 746; t_hs_e = 853; t_act_w = 704; t_vs_h = vs_h;
    endtask

    // scenario tasks
    task automatic test_reset();
        apply_reset();
        checks++; if (hperiod !== 10'd0) begin failures++; $display("FAIL reset_hperiod: got %0d want 0", hperiod); end
        checks++; if (vlines !== 10'd0) begin failures++; $display("FAIL reset_vlines: got %0d want 0", vlines); end
        checks++; if (mode !== 1'b0) begin failures++; $display("FAIL reset_mode: got %0d want 0", mode); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %0d want 0", locked); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0d want 0", err); end
        checks++; if (hpos !== 10'd0) begin failures++; $display("FAIL reset_hpos: got %0d want 0", hpos); end
        checks++; if (vpos !== 9'd0) begin failures++; $display("FAIL reset_vpos: got %0d want 0", vpos); end
    endtask

    task automatic test_lock_640();
        set_640(0);
        drive_frame(FRAME_LINES);
        drive_frame(FRAME_LINES);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL l640_early_locked: got %0d want 0", locked); end
        checks++; if (vlines !== 10'd4) begin failures++; $display("FAIL l640_vlines: got %0d want 4", vlines); end
        checks++; if (hperiod !== 10'd800) begin failures++; $display("FAIL l640_hperiod: got %0d want 800", hperiod); end
        drive_line(0, t_hlen);
        drive_line(1, t_hlen);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL l640_pre_vs_locked: got %0d want 0", locked); end
        drive_pixels(2, 0, 0);  // third vsync edge
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL l640_locked: got %0d want 1", locked); end
        checks++; if (mode !== 1'b1) begin failures++; $display("FAIL l640_mode: got %0d want 1", mode); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL l640_err: got %0d want 0", err); end
        drive_pixels(2, 1, t_hlen - 1);
        drive_line(3, t_hlen);
        drive_frame(FRAME_LINES);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL l640_hold_locked: got %0d want 1", locked); end
        checks++; if (vlines !== 10'd4) begin failures++; $display("FAIL l640_hold_vlines: got %0d want 4", vlines); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL l640_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_short_line();
        int base;
        base = err_cnt;
        drive_line(0, 799);
        drive_pixels(1, 0, t_hs_s);  // hsync edge ending the 799-clock line
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL short_err_pulse: got %0d want 1", err); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL short_locked: got %0d want 0", locked); end
        checks++; if (hperiod !== 10'd799) begin failures++; $display("FAIL short_hperiod: got %0d want 799", hperiod); end
        drive_pixels(1, t_hs_s + 1, t_hs_s + 1);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL short_err_end: got %0d want 0", err); end
        drive_pixels(1, t_hs_s + 2, t_hlen - 1);
        drive_line(2, t_hlen);
        drive_line(3, t_hlen);
        drive_frame(FRAME_LINES);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL short_relock_early: got %0d want 0", locked); end
        drive_frame(FRAME_LINES);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL short_relock: got %0d want 1", locked); end
        checks++; if (err_cnt !== base + 1) begin failures++; $display("FAIL short_err_cycles: got %0d want %0d", err_cnt, base + 1); end
        checks++; if (hperiod !== 10'd800) begin failures++; $display("FAIL short_hperiod_after: got %0d want 800", hperiod); end
    endtask

    task automatic test_timeout();
        int base;
        base = err_cnt;
        repeat (1100) step(1'b1, 1'b1, 1'b1);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL tmo_locked: got %0d want 0", locked); end
        checks++; if (err_cnt !== base + 1) begin failures++; $display("FAIL tmo_err_cycles: got %0d want %0d", err_cnt, base + 1); end
        checks++; if (hperiod !== 10'd800) begin failures++; $display("FAIL tmo_hperiod_hold: got %0d want 800", hperiod); end
        drive_line(0, 850);
        checks++; if (hperiod !== 10'd800) begin failures++; $display("FAIL tmo_first_hs: got %0d want 800", hperiod); end
        drive_line(1, 800);
        checks++; if (hperiod !== 10'd850) begin failures++; $display("FAIL tmo_second_hs: got %0d want 850", hperiod); end
    endtask

    task automatic test_lock_704();
        int base;
        base = err_cnt;
        set_704(0);
        checks++; if (mode !== 1'b1) begin failures++; $display("FAIL l704_mode_held: got %0d want 1", mode); end
        drive_frame(FRAME_LINES);
        drive_frame(FRAME_LINES);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL l704_early_locked: got %0d want 0", locked); end
        drive_line(0, t_hlen);
        drive_line(1, t_hlen);
        drive_pixels(2, 0, 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL l704_locked: got %0d want 1", locked); end
        checks++; if (mode !== 1'b0) begin failures++; $display("FAIL l704_mode: got %0d want 0", mode); end
        checks++; if (hperiod !== 10'd910) begin failures++; $display("FAIL l704_hperiod: got %0d want 910", hperiod); end
        drive_pixels(2, 1, t_hlen - 1);
        drive_line(3, t_hlen);
        checks++; if (vlines !== 10'd4) begin failures++; $display("FAIL l704_vlines: got %0d want 4", vlines); end
        checks++; if (err_cnt !== base) begin failures++; $display("FAIL l704_err_cycles: got %0d want %0d", err_cnt, base); end
    endtask

    task automatic test_short_frames();
        int base;
        apply_reset();
        base = err_cnt;
        set_640(656);  // vsync edge coincides with the hsync edge
        for (int f = 0; f < 3; f++) drive_frame(FRAME_LINES - 1);
        checks++; if (vlines !== 10'd3) begin failures++; $display("FAIL sf_vlines_short: got %0d want 3", vlines); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sf_no_lock: got %0d want 0", locked); end
        drive_frame(FRAME_LINES);
        drive_frame(FRAME_LINES);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sf_early_locked: got %0d want 0", locked); end
        checks++; if (vlines !== 10'd4) begin failures++; $display("FAIL sf_vlines_full: got %0d want 4", vlines); end
        drive_frame(FRAME_LINES);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sf_locked: got %0d want 1", locked); end
        checks++; if (mode !== 1'b1) begin failures++; $display("FAIL sf_mode: got %0d want 1", mode); end
        checks++; if (err_cnt !== base) begin failures++; $display("FAIL sf_err_cycles: got %0d want %0d", err_cnt, base); end
    endtask

    task automatic test_hpos_vpos();
        int exp_h, exp_v;
        for (int l = 0; l < FRAME_LINES; l++) begin
            for (int h = 0; h < t_hlen; h++) begin
                drive_pixels(l, h, h);
                exp_h = (l < ACT_LINES && h < t_act_w) ? h : t_act_w - 1;
                exp_v = (l < ACT_LINES) ? l : ACT_LINES - 1;
                if (h == 0 || h == 1 || h == t_act_w - 1 || h == t_act_w || h == t_hlen - 1) begin
                    checks++;
                    if (hpos !== exp_h[9:0]) begin
                        failures++; $display("FAIL pos_hpos line %0d h %0d: got %0d want %0d", l, h, hpos, exp_h);
                    end
                    checks++;
                    if (vpos !== exp_v[8:0]) begin
                        failures++; $display("FAIL pos_vpos line %0d h %0d: got %0d want %0d", l, h, vpos, exp_v);
                    end
                end
            end
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pos_locked: got %0d want 1", locked); end
    endtask

    initial begin
        rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        test_reset();
        test_lock_640();
        test_short_line();
        test_timeout();
        test_lock_704();
        test_short_frames();
        test_hpos_vpos();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
